// File: rtl/lsu_split_ctrl.sv
// Load/store unit access splitter.
// Turns one byte/half/word access at an arbitrary byte address into one or
// two word-aligned memory beats, then realigns and extends the load data.
//
// Handshakes:
//   req:  a request transfers on a rising edge where req_valid && req_ready.
//         req_ready is high only in IDLE. The req_* fields need only be valid
//         in that accepting cycle.
//   mem:  a beat completes on a rising edge where mem_req && mem_ready.
//         mem_rdata is sampled on that same edge. While mem_ready is low,
//         every mem_* output is held.
//   resp: resp_valid is a single-cycle pulse with no back-pressure.
//         resp_rdata and resp_split hold until the next pulse.
module lsu_split_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_split,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;

    // Fields captured when a request is accepted
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic        r_split;
    logic [3:0]  r_strb_hi;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_addr_hi;
    logic [31:0] r_lo;
    logic [31:0] r_hi;

    // Registered outputs
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_split;

    // Decode of the incoming request
    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [7:0]  w_strb8;
    logic        w_split;
    logic [63:0] w_wdata_sh;
    logic [31:0] w_base;
    logic [31:0] w_res_single;
    logic [31:0] w_res_double;

    // Shift the 64-bit {hi,lo} window down by the byte offset and extend
    function automatic logic [31:0] f_load_result(
        input logic [63:0] data,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [63:0] sh;
        logic [31:0] raw;
        logic [31:0] res;
        sh  = data >> {off, 3'b000};
        raw = sh[31:0];
        case (size)
            2'd0:    res = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    res = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Byte-lane mask for the access size; size 3 behaves as a word
    always_comb begin
        w_mask = 4'b1111;
        case (req_size)
            2'd0:    w_mask = 4'b0001;
            2'd1:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_off      = req_addr[1:0];
    assign w_strb8    = {4'b0000, w_mask} << w_off;
    assign w_split    = |w_strb8[7:4];
    assign w_wdata_sh = {32'd0, req_wdata} << {w_off, 3'b000};
    assign w_base     = {req_addr[31:2], 2'b00};

    // Load results for the two completion paths; stores always return 0
    assign w_res_single = r_we ? 32'd0
                               : f_load_result({32'd0, mem_rdata}, r_off, r_size, r_unsigned);
    assign w_res_double = r_we ? 32'd0
                               : f_load_result({mem_rdata, r_lo}, r_off, r_size, r_unsigned);

    // Main FSM: sequencing plus all registered memory and response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_off        <= 2'd0;
            r_split      <= 1'b0;
            r_strb_hi    <= 4'd0;
            r_wdata_hi   <= 32'd0;
            r_addr_hi    <= 32'd0;
            r_lo         <= 32'd0;
            r_hi         <= 32'd0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_we     <= 1'b0;
            r_mem_wstrb  <= 4'd0;
            r_mem_wdata  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_split <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_off       <= w_off;
                        r_split     <= w_split;
                        r_strb_hi   <= w_strb8[7:4];
                        r_wdata_hi  <= w_wdata_sh[63:32];
                        r_addr_hi   <= w_base + 32'd4;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_base;
                        r_mem_we    <= req_we;
                        r_mem_wstrb <= w_strb8[3:0];
                        r_mem_wdata <= w_wdata_sh[31:0];
                        r_state     <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (mem_ready) begin
                        r_lo <= mem_rdata;
                        r_hi <= 32'd0;
                        if (r_split) begin
                            r_mem_addr  <= r_addr_hi;
                            r_mem_wstrb <= r_strb_hi;
                            r_mem_wdata <= r_wdata_hi;
                            r_state     <= S_BEAT1;
                        end else begin
                            r_mem_req    <= 1'b0;
                            r_mem_we     <= 1'b0;
                            r_mem_wstrb  <= 4'd0;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_res_single;
                            r_resp_split <= 1'b0;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ready) begin
                        r_hi         <= mem_rdata;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_wstrb  <= 4'd0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_res_double;
                        r_resp_split <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_split = r_resp_split;
    assign dbg_state  = r_state;

endmodule
